// File: rtl/dtcm_ctrl_if.sv
// Command/response channel between the load/store unit (master) and the
// DTCM front end (slave).
interface dtcm_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output cmd_valid,
        output cmd_read,
        output cmd_addr,
        output cmd_wdata,
        output cmd_wmask,
        output rsp_ready,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  cmd_valid,
        input  cmd_read,
        input  cmd_addr,
        input  cmd_wdata,
        input  cmd_wmask,
        input  rsp_ready,
        output cmd_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/dtcm_ctrl.sv
// DTCM command/response front end: drives a single-port 1-cycle-latency RAM and
// returns in-order responses through a one-entry stage plus a 2-entry buffer.
module dtcm_ctrl #(
    parameter int          ADDR_WIDTH = 13,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    dtcm_ctrl_if.slave            bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wr_data,
    output logic                  ram_wr_en,
    output logic [3:0]            ram_wr_byte_en,
    input  logic [31:0]           ram_rd_data
);
    localparam int TAG_LSB = ADDR_WIDTH + 2;

    logic [1:0]  occ_reg;
    logic [1:0]  occ_next;
    logic        in_window;
    logic        accept;
    logic        consume;
    logic        addr_lsb_unused;

    // Stage P: the command accepted at the previous edge
    logic        p_valid_reg;
    logic        p_read_reg;
    logic        p_err_reg;
    logic [31:0] p_rdata;

    // Buffer B: responses that could not be handed out in their P cycle
    logic [31:0] b_rdata_reg [0:1];
    logic        b_err_reg   [0:1];
    logic        b_rd_ptr_reg;
    logic        b_wr_ptr_reg;
    logic [1:0]  b_count_reg;
    logic [1:0]  b_count_next;
    logic        b_empty;
    logic        b_push;
    logic        b_pop;

    assign addr_lsb_unused = ^bus.cmd_addr[1:0];

    assign in_window = (bus.cmd_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

    // Ready is a function of registered occupancy only, never of cmd_valid.
    assign bus.cmd_ready = !rst && (occ_reg < 2'd2);
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    assign ram_addr       = bus.cmd_addr[TAG_LSB-1:2];
    assign ram_wr_data    = bus.cmd_wdata;
    assign ram_wr_byte_en = bus.cmd_wmask;
    assign ram_wr_en      = accept && !bus.cmd_read && in_window;

    assign p_rdata = (p_valid_reg && p_read_reg && !p_err_reg) ? ram_rd_data : 32'd0;
    assign b_empty = (b_count_reg == 2'd0);

    assign bus.rsp_valid = !rst && (!b_empty || p_valid_reg);
    assign bus.rsp_rdata = b_empty ? p_rdata : b_rdata_reg[b_rd_ptr_reg];
    assign bus.rsp_err   = b_empty ? (p_valid_reg && p_err_reg) : b_err_reg[b_rd_ptr_reg];
    assign consume       = bus.rsp_valid && bus.rsp_ready;

    // RAM output is only valid for one cycle, so P must either leave through the
    // response port or be captured into B right now.
    assign b_push = p_valid_reg && !(b_empty && consume);
    assign b_pop  = consume && !b_empty;

    always_comb begin
        b_count_next = b_count_reg;
        case ({b_push, b_pop})
            2'b10:   b_count_next = b_count_reg + 2'd1;
            2'b01:   b_count_next = b_count_reg - 2'd1;
            default: b_count_next = b_count_reg;
        endcase
    end

    always_comb begin
        occ_next = occ_reg;
        case ({accept, consume})
            2'b10:   occ_next = occ_reg + 2'd1;
            2'b01:   occ_next = occ_reg - 2'd1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_reg      <= 2'd0;
            p_valid_reg  <= 1'b0;
            p_read_reg   <= 1'b0;
            p_err_reg    <= 1'b0;
            b_rd_ptr_reg <= 1'b0;
            b_wr_ptr_reg <= 1'b0;
            b_count_reg  <= 2'd0;
        end else begin
            occ_reg     <= occ_next;
            p_valid_reg <= accept;
            p_read_reg  <= accept && bus.cmd_read;
            p_err_reg   <= accept && !in_window;
            b_count_reg <= b_count_next;
            if (b_push) begin
                b_wr_ptr_reg <= !b_wr_ptr_reg;
            end
            if (b_pop) begin
                b_rd_ptr_reg <= !b_rd_ptr_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            always_ff @(posedge clk) begin
                if (rst) begin
                    b_rdata_reg[gi] <= 32'd0;
                    b_err_reg[gi]   <= 1'b0;
                end else if (b_push && (b_wr_ptr_reg == 1'(gi))) begin
                    b_rdata_reg[gi] <= p_rdata;
                    b_err_reg[gi]   <= p_err_reg;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Directed and randomized checks of dtcm_ctrl against a write-first RAM model
// and an in-order response scoreboard.
module tb_dtcm_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] ram_addr;
    logic [31:0] ram_wr_data;
    logic        ram_wr_en;
    logic [3:0]  ram_wr_byte_en;
    logic [31:0] ram_rd_data;

    int compared   = 0;
    int mismatched = 0;
    int accepts    = 0;
    int responses  = 0;

    logic [31:0] mem [0:8191];
    bit          mem_init_done = 1'b0;
    logic [31:0] shadow [0:15];
    logic [32:0] exp_q [$];

    dtcm_ctrl_if bus();

    dtcm_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .ram_addr       (ram_addr),
        .ram_wr_data    (ram_wr_data),
        .ram_wr_en      (ram_wr_en),
        .ram_wr_byte_en (ram_wr_byte_en),
        .ram_rd_data    (ram_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Single-port RAM, write-first, one-cycle read latency
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 32'd0;
            mem_init_done <= 1'b1;
            ram_rd_data   <= 32'd0;
        end else if (ram_wr_en) begin
            mem[ram_addr] <= merge(mem[ram_addr], ram_wr_data, ram_wr_byte_en);
            ram_rd_data   <= merge(mem[ram_addr], ram_wr_data, ram_wr_byte_en);
        end else begin
            ram_rd_data <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic rd, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] m);
        bus.cmd_valid = v;
        bus.cmd_read  = rd;
        bus.cmd_addr  = a;
        bus.cmd_wdata = wd;
        bus.cmd_wmask = m;
        #1;
    endtask

    task automatic sb_cycle();
        logic [32:0] e;
        int          idx;
        if (bus.cmd_valid && bus.cmd_ready) begin
            accepts++;
            idx = int'(bus.cmd_addr[5:2]);
            if (bus.cmd_addr[31:15] != 17'h10000) begin
                exp_q.push_back({1'b1, 32'd0});
            end else if (bus.cmd_read) begin
                exp_q.push_back({1'b0, shadow[idx]});
            end else begin
                shadow[idx] = merge(shadow[idx], bus.cmd_wdata, bus.cmd_wmask);
                exp_q.push_back({1'b0, 32'd0});
            end
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            check("sb_expected_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                responses++;
                check("sb_rdata", bus.rsp_rdata, e[31:0]);
                check("sb_err", 32'(bus.rsp_err), 32'(e[32]));
            end
        end
    endtask

    task automatic rand_cmd(input bit force_valid);
        logic [31:0] a;
        int          idx;
        idx = 32 + int'($urandom_range(0, 15));
        a   = (($urandom_range(0, 7) == 0) ? 32'h8001_0000 : 32'h8000_0000)
              + 32'(idx * 4) + 32'($urandom_range(0, 3));
        set_cmd(force_valid || ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
                $urandom, 4'($urandom_range(0, 15)));
    endtask

    task automatic drain();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            set_cmd(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
            sb_cycle();
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = 32'd0;
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

        // Reset state, with an in-window write presented during reset
        repeat (2) step();
        set_cmd(1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_ram_wr_en", 32'(ram_wr_en), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        step();
        rst = 1'b0;
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("ready_after_rst", 32'(bus.cmd_ready), 32'd1);
        check("rsp_valid_after_rst", 32'(bus.rsp_valid), 32'd0);

        // Full write then read-after-write
        bus.rsp_ready = 1'b1;
        step();
        set_cmd(1'b1, 1'b0, 32'h8000_0010, 32'h1122_3344, 4'hF);
        check("wr_ready", 32'(bus.cmd_ready), 32'd1);
        check("wr_en", 32'(ram_wr_en), 32'd1);
        check("wr_ram_addr", 32'(ram_addr), 32'd4);
        check("wr_byte_en", 32'(ram_wr_byte_en), 32'hF);
        step();
        set_cmd(1'b1, 1'b1, 32'h8000_0010, 32'd0, 4'd0);
        check("raw_rd_ready", 32'(bus.cmd_ready), 32'd1);
        check("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("wr_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("wr_rsp_err", 32'(bus.rsp_err), 32'd0);
        step();
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("raw_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("raw_rdata", bus.rsp_rdata, 32'h1122_3344);
        check("raw_err", 32'(bus.rsp_err), 32'd0);

        // Partial write merged with the earlier contents
        step();
        set_cmd(1'b1, 1'b0, 32'h8000_0010, 32'hAABB_CCDD, 4'b0101);
        check("pw_wr_en", 32'(ram_wr_en), 32'd1);
        check("pw_idle_rsp", 32'(bus.rsp_valid), 32'd0);
        step();
        set_cmd(1'b1, 1'b1, 32'h8000_0010, 32'd0, 4'd0);
        check("pw_wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        step();
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("pw_merge_rdata", bus.rsp_rdata, 32'h11BB_33DD);

        // Stall: three reads with rsp_ready low
        step();
        set_cmd(1'b1, 1'b0, 32'h8000_0020, 32'hCAFE_F00D, 4'hF);
        step();
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        step();
        bus.rsp_ready = 1'b0;
        set_cmd(1'b1, 1'b1, 32'h8000_0010, 32'd0, 4'd0);
        check("st_rd1_ready", 32'(bus.cmd_ready), 32'd1);
        check("st_rd1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        set_cmd(1'b1, 1'b1, 32'h8000_0020, 32'd0, 4'd0);
        check("st_rd2_ready", 32'(bus.cmd_ready), 32'd1);
        check("st_rd1_rdata_p", bus.rsp_rdata, 32'h11BB_33DD);
        step();
        set_cmd(1'b1, 1'b1, 32'h8000_0010, 32'd0, 4'd0);
        check("st_rd3_blocked", 32'(bus.cmd_ready), 32'd0);
        check("st_head_rdata", bus.rsp_rdata, 32'h11BB_33DD);
        step();
        check("st_still_blocked", 32'(bus.cmd_ready), 32'd0);
        check("st_head_hold", bus.rsp_rdata, 32'h11BB_33DD);
        bus.rsp_ready = 1'b1;
        step();
        check("st_ready_after_consume", 32'(bus.cmd_ready), 32'd1);
        check("st_rd2_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
        step();
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("st_rd3_rdata", bus.rsp_rdata, 32'h11BB_33DD);
        step();
        check("st_drained", 32'(bus.rsp_valid), 32'd0);

        // Stall with a write landing between a read and its response
        bus.rsp_ready = 1'b0;
        step();
        set_cmd(1'b1, 1'b1, 32'h8000_0010, 32'd0, 4'd0);
        step();
        set_cmd(1'b1, 1'b0, 32'h8000_0010, 32'h5566_7788, 4'hF);
        check("sw_wr_en", 32'(ram_wr_en), 32'd1);
        step();
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("sw_blocked", 32'(bus.cmd_ready), 32'd0);
        check("sw_rd_captured", bus.rsp_rdata, 32'h11BB_33DD);
        bus.rsp_ready = 1'b1;
        step();
        check("sw_wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("sw_wr_rsp_rdata", bus.rsp_rdata, 32'd0);
        step();
        set_cmd(1'b1, 1'b1, 32'h8000_0010, 32'd0, 4'd0);
        check("sw_empty", 32'(bus.rsp_valid), 32'd0);
        step();
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("sw_new_data", bus.rsp_rdata, 32'h5566_7788);

        // Out-of-window write aliasing word 0 must not touch the RAM
        step();
        set_cmd(1'b1, 1'b0, 32'h8000_8000, 32'hFFFF_FFFF, 4'hF);
        check("oow_wr_en", 32'(ram_wr_en), 32'd0);
        check("oow_ready", 32'(bus.cmd_ready), 32'd1);
        step();
        set_cmd(1'b1, 1'b1, 32'h8000_0000, 32'd0, 4'd0);
        check("oow_rsp_err", 32'(bus.rsp_err), 32'd1);
        check("oow_rsp_rdata", bus.rsp_rdata, 32'd0);
        step();
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("oow_word0_err", 32'(bus.rsp_err), 32'd0);
        check("oow_word0_rdata", bus.rsp_rdata, 32'd0);
        step();

        // Random stream at full rate
        accepts = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            rand_cmd(1'b1);
            sb_cycle();
        end
        check("stream_accepts", 32'(accepts), 32'd100);
        drain();

        // Random stream with random backpressure
        accepts   = 0;
        responses = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            bus.rsp_ready = 1'($urandom_range(0, 1));
            rand_cmd(1'b0);
            sb_cycle();
        end
        drain();
        check("bp_rsp_count", 32'(responses), 32'(accepts));

        // Reset while two responses are outstanding
        bus.rsp_ready = 1'b0;
        step();
        set_cmd(1'b1, 1'b0, 32'h8000_0040, 32'h1234_5678, 4'hF);
        step();
        set_cmd(1'b1, 1'b1, 32'h8000_0040, 32'd0, 4'd0);
        step();
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("mr_full", 32'(bus.cmd_ready), 32'd0);
        step();
        rst = 1'b1;
        #1;
        check("mr_rst_ready", 32'(bus.cmd_ready), 32'd0);
        check("mr_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        check("mr_ready_after", 32'(bus.cmd_ready), 32'd1);
        check("mr_no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
        step();
        set_cmd(1'b1, 1'b1, 32'h8000_0040, 32'd0, 4'd0);
        check("mr_still_empty", 32'(bus.rsp_valid), 32'd0);
        step();
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("mr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("mr_ram_kept", bus.rsp_rdata, 32'h1234_5678);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/dtcm_ctrl.md
# dtcm_ctrl

Command/response front end for the data tightly-coupled memory. It accepts valid/ready byte-addressed requests from the core's load/store unit and drives the single-port DTCM RAM (13-bit word address, 32-bit data, 4 byte enables, 1-cycle read latency, unregistered output). It returns one response per command, in order, through a 2-entry response buffer so that backpressure on the response channel never drops RAM read data.

## Interface
- ADDR_WIDTH, 13: RAM word-address width; window is 2^(ADDR_WIDTH+2) bytes.
- BASE_ADDR, 32'h8000_0000: window base; bits [ADDR_WIDTH+1:0] must be zero.
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  request present.
- cmd_ready  out  1  request accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_read  in  1  1 = read, 0 = write.
- cmd_addr  in  32  byte address; bits [1:0] ignored.
- cmd_wdata  in  32  write data.
- cmd_wmask  in  4  byte write enables; bit i covers wdata[8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a rising edge.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  address outside window.
- ram_addr  out  ADDR_WIDTH  = cmd_addr[ADDR_WIDTH+1:2], combinational.
- ram_wr_data  out  32  = cmd_wdata, combinational.
- ram_wr_en  out  1  accepted, in-window write this cycle.
- ram_wr_byte_en  out  4  = cmd_wmask, combinational.
- ram_rd_data  in  32  RAM output, valid the cycle after the address edge.

## Operation
- In window: cmd_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2].
- occ: count of accepted commands without a consumed response, 0..2. cmd_ready = !rst && occ < 2. The ready value depends only on registered state and not on cmd_valid.
- Accept, read, in window: the RAM samples ram_addr at the same edge. Data is taken from ram_rd_data in the next cycle.
- Accept, write, in window: ram_wr_en = 1 in the accept cycle. cmd_wmask = 0 is a legal no-op write and still gets a response.
- Accept, out of window: ram_wr_en = 0. The response has rsp_err = 1 and rsp_rdata = 0.
- Pipeline structure:
  - Stage P: 1 entry, loaded on accept. Holds {valid, read, err}.
  - Buffer B: 2-entry FIFO of {rdata, err}.
- Response source: head of B if B is non-empty, otherwise stage P, with rdata = P.read && !P.err ? ram_rd_data : 0.
- If P is valid and not sourced-and-consumed this cycle, P is pushed into B with its rdata captured. The captured rdata must not be re-read later, because a subsequent write changes ram_rd_data.
- occ ≤ 2 guarantees B never overflows. Responses stay strictly in order.
- Update rule: occ' = occ + accept − (rsp_valid && rsp_ready). Simultaneous accept and consume leaves occ unchanged.

## Timing
- Reset values: cmd_ready = 0 (while rst is high), rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, ram_wr_en = 0, occ = 0, P and B empty.
- Reset mid-operation: in-flight and buffered responses are discarded and never presented. RAM contents are untouched.
- cmd_ready = 1 in the first cycle after rst deasserts.
- Latency: a command accepted at edge t gives rsp_valid = 1 in cycle t+1 (from P, combinational from ram_rd_data).
- Throughput: 1 command/cycle sustained while rsp_ready = 1.
- With rsp_ready held at 0, at most 2 commands are accepted; cmd_ready falls after the second.
- After a stall, cmd_ready rises in the cycle after the first consume.
- Read-after-write to the same word on consecutive accepts returns the new data.
- Read-after-write is byte-merged per cmd_wmask.

## Test plan
- Write 0x11223344 to 0x8000_0010 with mask 0xF, then read 0x8000_0010. Required: both accepted back-to-back; the read response (cycle t+1) returns 0x11223344 with rsp_err = 0.
- Write 0xAABBCCDD with mask 4'b0101 over that word, then read. Required: returns 0x11BB33DD.
- Issue 3 reads with rsp_ready = 0. Required: the first two are accepted, then cmd_ready = 0. Also write a different value between reads in a separate run. Required: when rsp_ready rises, the buffered data come out in order, unchanged, 1 per cycle.
- Write to 0x8000_8000 (just outside an 8 KB·4 window) with mask 0xF. Required: ram_wr_en stays 0; response has rsp_err = 1 and rsp_rdata = 0; a read of 0x8000_0000 is unchanged.
- Stream 100 random reads/writes with rsp_ready = 1. Required: 100 accepts in 100 cycles, responses matched against a reference model. Repeat with random rsp_ready: no loss, no reorder.
- Assert rst for 1 cycle with occ = 2. Required: the next cycle has rsp_valid = 0 and cmd_ready = 0; cmd_ready = 1 the cycle after; previously written RAM data is still readable.
